// File: rtl/ids_lab05_prio_encoder_hs_pkg.sv
// Shared sizing and helpers for the lab 05 priority encoder with a valid/ready output.
// The decoder blocks of the lab reuse the same code width and one-hot helper.
package ids_lab05_prio_encoder_hs_pkg;

  localparam int W = 2;
  localparam int N = 1 << W;

  typedef logic [W-1:0] code_t;
  typedef logic [N-1:0] req_t;

  function automatic req_t onehot(input code_t idx);
    req_t r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ids_lab05_prio_encoder_hs_if.sv
// Request inputs and the encoded valid/ready output of the priority encoder.
// slave is the encoder's view; master is the view of the requester/consumer side.
interface ids_lab05_prio_encoder_hs_if;
  import ids_lab05_prio_encoder_hs_pkg::*;

  logic  E;
  req_t  D;
  logic  rdy;
  code_t A;
  logic  V;
  logic  MISS;

  modport slave (
    input  E,
    input  D,
    input  rdy,
    output A,
    output V,
    output MISS
  );

  modport master (
    output E,
    output D,
    output rdy,
    input  A,
    input  V,
    input  MISS
  );

endinterface

// File: rtl/ids_lab05_prio_enc_comb.sv
// Combinational priority encoder: index of the highest set bit, idx=0 when nothing is set.
module ids_lab05_prio_enc_comb
  import ids_lab05_prio_encoder_hs_pkg::*;
#(
  parameter int CW = W
) (
  input  logic [(1<<CW)-1:0] vec,
  output logic [CW-1:0]      idx,
  output logic               any
);

  localparam int CN = 1 << CW;

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < CN; i++) begin
      if (vec[i]) begin
        idx = i[CW-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ids_lab05_prio_encoder_hs.sv
// Sticky request capture with highest-index-first emission over a valid/ready output.
// A, V and MISS are driven straight from flops; no input reaches an output combinationally.
module ids_lab05_prio_encoder_hs
  import ids_lab05_prio_encoder_hs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  ids_lab05_prio_encoder_hs_if.slave bus
);

  req_t  din;
  req_t  cand;
  req_t  pending;
  logic  load;
  code_t idx_next;
  logic  any_next;

  code_t a_q;
  logic  v_q;
  logic  miss_q;

  always_comb begin
    din  = bus.E ? bus.D : '0;
    cand = pending | din;
    load = ~v_q | bus.rdy;
  end

  ids_lab05_prio_enc_comb #(.CW(W)) u_enc (
    .vec (cand),
    .idx (idx_next),
    .any (any_next)
  );

  // A request on the line currently held in A is not in pending, so it is a fresh capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      a_q     <= '0;
      v_q     <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      miss_q <= |(din & pending);
      if (load) begin
        if (any_next) begin
          a_q     <= idx_next;
          v_q     <= 1'b1;
          pending <= cand & ~onehot(idx_next);
        end else begin
          v_q     <= 1'b0;
          pending <= '0;
        end
      end else begin
        pending <= cand;
      end
    end
  end

  assign bus.A    = a_q;
  assign bus.V    = v_q;
  assign bus.MISS = miss_q;

endmodule

// File: tb/tb_ids_lab05_prio_encoder_hs.sv
// Directed bench: stimulus pushes expected codes; a negedge monitor pops on each handshake.
module tb_ids_lab05_prio_encoder_hs;
  import ids_lab05_prio_encoder_hs_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_q[$];

  ids_lab05_prio_encoder_hs_if bus ();

  ids_lab05_prio_encoder_hs dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Handshake completes on the next rising edge when V and rdy are both high at the negedge.
  always @(negedge clk) begin
    if (rst_n && bus.V === 1'b1 && bus.rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_handshake", int'(bus.A), -1);
      end else begin
        chk("handshake_code", int'(bus.A), exp_q.pop_front());
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.E = 1'b1;
    bus.D = 4'b1111;
    bus.rdy = 1'b1;

    // 1. reset holds everything cleared even with requests on D
    #1;
    chk("rst_V", int'(bus.V), 0);
    chk("rst_A", int'(bus.A), 0);
    chk("rst_MISS", int'(bus.MISS), 0);
    cyc(2);
    chk("rst_hold_V", int'(bus.V), 0);
    bus.D = 4'b0000;
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_V", int'(bus.V), 0);

    // 2. single request
    bus.D = 4'b0100;
    exp_q.push_back(2);
    cyc();
    bus.D = 4'b0000;
    chk("single_V", int'(bus.V), 1);
    chk("single_A", int'(bus.A), 2);
    cyc();
    chk("single_done_V", int'(bus.V), 0);
    chk("single_q_empty", exp_q.size(), 0);

    // 3. priority with backpressure
    bus.rdy = 1'b0;
    bus.D = 4'b1011;
    exp_q.push_back(3);
    exp_q.push_back(1);
    exp_q.push_back(0);
    cyc();
    bus.D = 4'b0000;
    chk("prio_V", int'(bus.V), 1);
    chk("prio_A", int'(bus.A), 3);
    cyc(2);
    chk("prio_hold_V", int'(bus.V), 1);
    chk("prio_hold_A", int'(bus.A), 3);
    bus.rdy = 1'b1;
    cyc();
    chk("prio_second_A", int'(bus.A), 1);
    cyc();
    chk("prio_third_A", int'(bus.A), 0);
    cyc();
    chk("prio_done_V", int'(bus.V), 0);
    chk("prio_q_empty", exp_q.size(), 0);

    // 4. enable gating, then drain with E low
    bus.E = 1'b0;
    bus.D = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("gated_V", int'(bus.V), 0);
    end
    bus.D = 4'b0011;
    bus.E = 1'b1;
    bus.rdy = 1'b0;
    exp_q.push_back(1);
    exp_q.push_back(0);
    cyc();
    chk("pend_A", int'(bus.A), 1);
    bus.D = 4'b0000;
    bus.E = 1'b0;
    bus.rdy = 1'b1;
    cyc();
    chk("drain_A", int'(bus.A), 0);
    chk("drain_V", int'(bus.V), 1);
    cyc();
    chk("drain_done_V", int'(bus.V), 0);
    chk("drain_q_empty", exp_q.size(), 0);

    // 5. MISS and merge on line 0
    bus.E = 1'b1;
    bus.rdy = 1'b0;
    bus.D = 4'b0001;
    cyc();
    chk("miss_e1_V", int'(bus.V), 1);
    chk("miss_e1_A", int'(bus.A), 0);
    chk("miss_e1_MISS", int'(bus.MISS), 0);
    cyc();
    chk("miss_e2_MISS", int'(bus.MISS), 0);
    cyc();
    chk("miss_e3_MISS", int'(bus.MISS), 1);
    bus.D = 4'b0000;
    bus.rdy = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(0);
    cyc();
    chk("miss_pulse_end", int'(bus.MISS), 0);
    chk("miss_second_V", int'(bus.V), 1);
    cyc();
    chk("miss_done_V", int'(bus.V), 0);
    chk("miss_q_empty", exp_q.size(), 0);
    cyc();
    chk("miss_quiet_V", int'(bus.V), 0);

    // 6. async reset mid-operation with pending 0110
    bus.rdy = 1'b0;
    bus.D = 4'b1110;
    cyc();
    bus.D = 4'b0000;
    chk("pre_rst_V", int'(bus.V), 1);
    chk("pre_rst_A", int'(bus.A), 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_V", int'(bus.V), 0);
    chk("async_rst_A", int'(bus.A), 0);
    chk("async_rst_MISS", int'(bus.MISS), 0);
    bus.rdy = 1'b1;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("after_rst_V", int'(bus.V), 0);
    end
    chk("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
